// File: rtl/rx_uart_ctrl.sv
// Receive-side controller for rx_uart: drains bytes into a FWFT FIFO and drives baud_div.
// Define RX_CTRL_AUTOBAUD_EN to include start-bit autobaud measurement on rx_pin.
module rx_uart_ctrl #(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] DEFAULT_DIV  = 16'd217,
    parameter logic [15:0] AUTOBAUD_MIN = 16'd8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_pin,
    input  logic                          rx_done_in,
    input  logic [7:0]                    rx_byte_in,
    output logic                          rx_read_out,
    output logic [15:0]                   baud_div_out,
    input  logic                          autobaud_start,
    output logic                          autobaud_busy,
    output logic                          autobaud_done,
    input  logic                          pop,
    output logic [7:0]                    dout,
    output logic                          empty_n,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] DR_IDLE = 1'b0;
    localparam logic [0:0] DR_ACK  = 1'b1;

    logic [0:0]    dr_state_reg;
    logic          rx_read_reg;
    logic          discard;
    logic          push_req;
    logic          push_ok;
    logic          pop_ok;
    logic          full;
    logic          empty;
    logic          ovf_set;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;

    // Drain FSM: the ACK gap lets rx_done fall before it is looked at again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dr_state_reg <= DR_IDLE;
            rx_read_reg  <= 1'b0;
        end else begin
            case (dr_state_reg)
                DR_IDLE: begin
                    if (rx_done_in) begin
                        dr_state_reg <= DR_ACK;
                        rx_read_reg  <= 1'b1;
                    end
                end
                default: begin
                    dr_state_reg <= DR_IDLE;
                    rx_read_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign push_req = (dr_state_reg == DR_IDLE) && rx_done_in && !discard;
    assign full     = (count_reg == CW'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push_req && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign ovf_set  = push_req && full && !pop;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset; dout is masked while empty so it reads 0 after reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= rx_byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign rx_read_out = rx_read_reg;
    assign dout        = empty ? 8'h00 : mem[rd_ptr_reg];
    assign empty_n     = !empty;
    assign count       = count_reg;
    assign overflow    = overflow_reg;

`ifdef RX_CTRL_AUTOBAUD_EN
    localparam logic [1:0] AB_IDLE      = 2'd0;
    localparam logic [1:0] AB_WAIT_HIGH = 2'd1;
    localparam logic [1:0] AB_WAIT_FALL = 2'd2;
    localparam logic [1:0] AB_MEASURE   = 2'd3;

    logic        rx_meta_reg;
    logic        rx_sync_reg;
    logic [1:0]  ab_state_reg;
    logic [15:0] cnt_reg;
    logic [15:0] baud_div_reg;
    logic        busy_reg;
    logic        done_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            ab_state_reg <= AB_IDLE;
            cnt_reg      <= '0;
            baud_div_reg <= DEFAULT_DIV;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            rx_meta_reg <= rx_pin;
            rx_sync_reg <= rx_meta_reg;
            done_reg    <= 1'b0;
            case (ab_state_reg)
                AB_IDLE: begin
                    if (autobaud_start) begin
                        ab_state_reg <= AB_WAIT_HIGH;
                        busy_reg     <= 1'b1;
                    end
                end
                AB_WAIT_HIGH: begin
                    if (rx_sync_reg) begin
                        ab_state_reg <= AB_WAIT_FALL;
                    end
                end
                AB_WAIT_FALL: begin
                    if (!rx_sync_reg) begin
                        ab_state_reg <= AB_MEASURE;
                        cnt_reg      <= 16'd1;
                    end
                end
                default: begin
                    // Being in MEASURE with the pin high means the rising edge just arrived.
                    if (!rx_sync_reg) begin
                        if (cnt_reg != 16'hFFFF) begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end else if (cnt_reg >= AUTOBAUD_MIN) begin
                        baud_div_reg <= cnt_reg;
                        done_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                        ab_state_reg <= AB_IDLE;
                    end else begin
                        ab_state_reg <= AB_WAIT_FALL;
                    end
                end
            endcase
        end
    end

    assign discard       = busy_reg;
    assign baud_div_out  = baud_div_reg;
    assign autobaud_busy = busy_reg;
    assign autobaud_done = done_reg;
`else
    logic unused_ab;
    assign unused_ab     = &{1'b0, rx_pin, autobaud_start};
    assign discard       = 1'b0;
    assign baud_div_out  = DEFAULT_DIV;
    assign autobaud_busy = 1'b0;
    assign autobaud_done = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart_ctrl.sv
// Directed bench for rx_uart_ctrl: drain handshake, FIFO/overflow edges, autobaud and reset.
`timescale 1ns/1ps
module tb_rx_uart_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_pin;
    logic        rx_done_in;
    logic [7:0]  rx_byte_in;
    logic        rx_read_out;
    logic [15:0] baud_div_out;
    logic        autobaud_start;
    logic        autobaud_busy;
    logic        autobaud_done;
    logic        pop;
    logic [7:0]  dout;
    logic        empty_n;
    logic [4:0]  count;
    logic        overflow;
    logic        overflow_clr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rx_uart_ctrl #(
        .FIFO_DEPTH(16), .DEFAULT_DIV(16'd217), .AUTOBAUD_MIN(16'd8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin),
        .rx_done_in(rx_done_in), .rx_byte_in(rx_byte_in), .rx_read_out(rx_read_out),
        .baud_div_out(baud_div_out), .autobaud_start(autobaud_start),
        .autobaud_busy(autobaud_busy), .autobaud_done(autobaud_done),
        .pop(pop), .dout(dout), .empty_n(empty_n), .count(count),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_div(input string tag, input logic [15:0] exp);
        total_cnt++;
        assert ((baud_div_out + 16'd2 >= exp) && (baud_div_out <= exp + 16'd2)) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d+-2", tag, baud_div_out, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done_in = 1'b1;
        rx_byte_in = b;
        tick();
        rx_done_in = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, dout, exp);
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (autobaud_done) seen = 1'b1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rx_read"}, rx_read_out, 0);
        check({tag, "_baud"}, baud_div_out, 217);
        check({tag, "_busy"}, autobaud_busy, 0);
        check({tag, "_done"}, autobaud_done, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty_n"}, empty_n, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; rx_pin = 1'b1; rx_done_in = 1'b0; rx_byte_in = 8'h00;
        autobaud_start = 1'b0; pop = 1'b0; overflow_clr = 1'b0;
        repeat (3) tick();
        check_reset_state("rst");
        rst_n = 1'b1;
        tick();

        // Single byte: ack pulse the cycle after rx_done, head visible at once.
        rx_done_in = 1'b1; rx_byte_in = 8'hA5;
        tick();
        rx_done_in = 1'b0;
        check("t1_rx_read", rx_read_out, 1);
        check("t1_empty_n", empty_n, 1);
        check("t1_dout", dout, 8'hA5);
        check("t1_count", count, 1);
        tick();
        check("t1_rx_read_drop", rx_read_out, 0);
        check("t1_count_hold", count, 1);
        pop_expect("t1_pop", 8'hA5);
        check("t1_empty", empty_n, 0);
        pop = 1'b1; tick(); pop = 1'b0;
        check("empty_pop_count", count, 0);
        check("empty_pop_empty_n", empty_n, 0);

        // Fill, overflow, drain in order, clear.
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("t2_full_count", count, 16);
        check("t2_no_ovf", overflow, 0);
        send_byte(8'h10);
        check("t2_ovf", overflow, 1);
        check("t2_count_after_ovf", count, 16);
        for (int i = 0; i < 16; i++) pop_expect($sformatf("t2_pop%0d", i), 8'(i));
        check("t2_drained", count, 0);
        check("t2_ovf_sticky", overflow, 1);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // Full FIFO: overflow beats clear, then push+pop in one cycle.
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        rx_done_in = 1'b1; rx_byte_in = 8'h99; overflow_clr = 1'b1;
        tick();
        rx_done_in = 1'b0; overflow_clr = 1'b0;
        check("t3_ovf_wins", overflow, 1);
        tick();
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        check("t3_ovf_clr", overflow, 0);
        check("t3_head", dout, 8'h20);
        rx_done_in = 1'b1; rx_byte_in = 8'h77; pop = 1'b1;
        tick();
        rx_done_in = 1'b0; pop = 1'b0;
        check("t3_count_same", count, 16);
        check("t3_no_ovf", overflow, 0);
        tick();
        for (int i = 1; i < 16; i++) pop_expect($sformatf("t3_pop%0d", i), 8'h20 + 8'(i));
        pop_expect("t3_pop_last", 8'h77);
        check("t3_drained", count, 0);

`ifdef RX_CTRL_AUTOBAUD_EN
        // Armed: a 3-cycle glitch is ignored, a byte while busy is acked but dropped.
        autobaud_start = 1'b1; tick(); autobaud_start = 1'b0;
        check("t5_busy", autobaud_busy, 1);
        repeat (5) tick();
        rx_pin = 1'b0; repeat (3) tick(); rx_pin = 1'b1;
        repeat (6) tick();
        check("t5_glitch_busy", autobaud_busy, 1);
        check("t5_glitch_div", baud_div_out, 217);
        rx_done_in = 1'b1; rx_byte_in = 8'hEE;
        tick();
        rx_done_in = 1'b0;
        check("t5_busy_ack", rx_read_out, 1);
        check("t5_busy_nopush", count, 0);
        tick();
        rx_pin = 1'b0; repeat (217) tick(); rx_pin = 1'b1;
        wait_done(seen);
        check("t5_done_seen", seen, 1);
        check_div("t5_div", 16'd217);
        check("t5_idle", autobaud_busy, 0);
        tick();
        check("t5_done_pulse", autobaud_done, 0);

        // Clean 434-cycle start bit.
        autobaud_start = 1'b1; tick(); autobaud_start = 1'b0;
        repeat (4) tick();
        rx_pin = 1'b0; repeat (434) tick(); rx_pin = 1'b1;
        wait_done(seen);
        check("t4_done_seen", seen, 1);
        check_div("t4_div", 16'd434);
        check("t4_idle", autobaud_busy, 0);
        tick();
        check("t4_done_pulse", autobaud_done, 0);
        check_div("t4_div_hold", 16'd434);
        check("t4_ovf", overflow, 0);
`else
        // Autobaud absent: start ignored, bytes always pushed.
        autobaud_start = 1'b1; tick(); autobaud_start = 1'b0;
        check("nab_busy", autobaud_busy, 0);
        rx_pin = 1'b0; repeat (20) tick(); rx_pin = 1'b1;
        repeat (5) tick();
        check("nab_done", autobaud_done, 0);
        check("nab_div", baud_div_out, 217);
        send_byte(8'h5A);
        check("nab_push", count, 1);
        pop_expect("nab_pop", 8'h5A);
`endif

        // Reset with data queued, the drain FSM in ACK and (if present) a measurement running.
        send_byte(8'h42);
        check("t6_pre_count", count, 1);
`ifdef RX_CTRL_AUTOBAUD_EN
        autobaud_start = 1'b1; tick(); autobaud_start = 1'b0;
        repeat (4) tick();
        rx_pin = 1'b0; repeat (50) tick();
        check("t6_measuring", autobaud_busy, 1);
`endif
        rx_done_in = 1'b1; rx_byte_in = 8'h43;
        tick();
        rx_done_in = 1'b0;
        check("t6_in_ack", rx_read_out, 1);
        rst_n = 1'b0;
        tick();
        check_reset_state("t6");
        rx_pin = 1'b1; rst_n = 1'b1;
        repeat (10) tick();
        check("t6_post_div", baud_div_out, 217);
        check("t6_post_busy", autobaud_busy, 0);
        check("t6_post_count", count, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
